// File: rtl/fetch_decode_buffer.sv
// In-order IF/ID buffer: pc/instruction queue with field split and NOP bubble.
// Define FETCH_PERF_CNT_EN to add the stall_cnt and flush_cnt counters.
module fetch_decode_buffer #(
   parameter int PCW   = 32,
   parameter int IW    = 32,
   parameter int REGW  = 4,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PCW-1:0]  in_pc,
   input  logic [IW-1:0]   in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PCW-1:0]  out_pc,
   output logic [1:0]      op,
   output logic [1:0]      inst,
   output logic            flagV,
   output logic [REGW-1:0] r1,
   output logic [REGW-1:0] r2,
   output logic [REGW-1:0] r3,
   output logic [IW-6:0]   imm
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PCW-1:0] pc_mem [DEPTH];
   logic [IW-1:0]  ir_mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           push;
   logic           pop;
   logic           empty;
   logic [PCW-1:0] head_pc;
   logic [IW-1:0]  head_ir;

   assign empty     = (count == '0);
   // Forced low during flush so fetch never sees a dropped word as taken.
   assign in_ready  = ~rst & ~flush & (count != FULL);
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr] <= in_pc;
         ir_mem[wr_ptr] <= in_instr;
      end
   end

   assign head_pc = pc_mem[rd_ptr];
   assign head_ir = ir_mem[rd_ptr];

   always_comb begin
      out_pc = '0;
      op     = 2'b00;
      inst   = 2'b10;
      flagV  = 1'b0;
      r1     = '0;
      r2     = '0;
      r3     = '0;
      imm    = '0;
      if (!empty) begin
         out_pc = head_pc;
         op     = head_ir[IW-1:IW-2];
         inst   = head_ir[IW-3:IW-4];
         flagV  = head_ir[IW-5];
         r1     = head_ir[REGW-1:0];
         r2     = head_ir[2*REGW-1:REGW];
         r3     = head_ir[3*REGW-1:2*REGW];
         imm    = head_ir[IW-6:0];
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (in_valid && !in_ready && !flush && !(&stall_cnt))
            stall_cnt <= stall_cnt + 32'd1;
         if (flush && !empty && !(&flush_cnt))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Parametrised successor to the IF/ID pipeline register of the vector ASIP.
- Sits between instruction fetch and decode/register-read.
- Accepts {pc, instruction} from fetch over a valid/ready handshake and holds them in a DEPTH-entry in-order buffer.
- Presents the head entry to decode already split into fields (op, inst, flagV, R1/R2/R3, immediate), with synchronous flush on taken jump/branch and a NOP bubble when empty.

Parameters:
- PCW, 32, program counter width.
- IW, 32, instruction width; must be >= 3*REGW+5.
- REGW, 4, register/vector-register index field width.
- DEPTH, 2, buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous flush (jump enable); discards all buffered and incoming entries.
- in_valid  in  1  fetch presents a valid pc/instruction.
- in_ready  out  1  buffer can accept this cycle.
- in_pc  in  PCW  pc of fetched instruction.
- in_instr  in  IW  fetched instruction word.
- out_valid  out  1  head entry valid for decode.
- out_ready  in  1  decode consumes head this cycle.
- out_pc  out  PCW  pc of head entry.
- op  out  2  instr[IW-1:IW-2].
- inst  out  2  instr[IW-3:IW-4].
- flagV  out  1  instr[IW-5], vector flag.
- r1  out  REGW  instr[REGW-1:0].
- r2  out  REGW  instr[2*REGW-1:REGW].
- r3  out  REGW  instr[3*REGW-1:2*REGW].
- imm  out  IW-5  instr[IW-6:0].

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap naturally) and count (0..DEPTH).
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). Depends only on state, so there is no combinational path from out_ready.
- out_valid = (count != 0).
- Push/pop occur on posedge clk. On simultaneous push and pop, count is unchanged and both pointers advance.
- Latency: an entry pushed into an empty buffer appears at out_valid/fields on the next cycle.
- Full: in_ready = 0. A pop in that cycle frees one slot visible next cycle; no same-cycle push.
- Empty: out_valid = 0; out_ready is ignored.
- Field outputs are pure slices of the head entry when count != 0.
- When count == 0, outputs carry the NOP bubble: op = 0, inst = 2'b10, flagV = 0, out_pc = 0, r1 = r2 = r3 = 0, imm = 0.
- flush (synchronous, highest priority after rst):
  - Next cycle count = 0, wr_ptr = rd_ptr = 0.
  - Any in_valid in the flush cycle is dropped; fetch must not see it as accepted, so in_ready is forced to 0 in the flush cycle.
  - out_valid stays as computed from state but no pop occurs.
- Cycle after flush: buffer empty, bubble on outputs, in_ready = 1.
- rst: asynchronous. Clears pointers and count to 0.
  - All outputs immediately take reset values: out_valid = 0, in_ready = 1 once rst deasserts (0 while asserted), fields = NOP bubble.
  - Entry storage contents need not be cleared.
  - rst mid-stream discards all entries.
- Entries are delivered strictly in push order; no reordering or duplication.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32) counting cycles with in_valid & ~in_ready & ~flush.
  - Adds output flush_cnt (32) counting cycles with flush = 1 and count != 0.
  - Both counters saturate at all-ones, reset to 0 on rst, and are unaffected by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset:
  - Assert rst mid-cycle with 2 entries buffered.
  - Outputs immediately go to op = 0, inst = 2'b10, out_valid = 0.
  - After release, in_ready = 1.
- Single pass:
  - Push pc = 0x100, instr = 0x8A00_0321 with out_ready = 1.
  - Next cycle: out_valid = 1, op = 2, inst = 0, flagV = 1, r1 = 1, r2 = 2, r3 = 3, imm = 0x2000321.
  - Following cycle: out_valid = 0.
- Backpressure:
  - out_ready = 0, push 3 instructions (pc 0x0, 0x4, 0x8).
  - in_ready drops after 2 accepts; the third is held by fetch.
  - Raise out_ready: pcs emerge 0x0, 0x4, 0x8 in order, with no loss.
- Flush:
  - Buffer full, in_valid = 1 with pc 0x20, flush = 1.
  - In that cycle in_ready = 0. Next cycle out_valid = 0 with the bubble, and pc 0x20 is never output.
  - Subsequent push of pc 0x40 appears one cycle later.
- Wrap-around: stream 10 instructions with randomly toggled out_ready; output pc sequence matches input exactly across pointer wrap.
- FETCH_PERF_CNT_EN:
  - Hold full for 5 cycles with in_valid = 1 → stall_cnt = 5.
  - One flush on a non-empty buffer → flush_cnt = 1.
